// File: rtl/triad_encode.sv
// triad_encode: serialises one half-strip hit into a three-bit triad
// (start bit, distrip bit, half-strip bit) followed by a programmable dead time.
// Optional feature: define TRIAD_ENCODE_DROPCNT_EN to add the saturating
// drop_cnt output that counts requests discarded while busy.
module triad_encode (
    input  logic        clock,
    input  logic        reset,
    input  logic        inject,
    input  logic [3:0]  h_strip,
    input  logic [3:0]  dead,
    output logic        triad,
    output logic        busy,
    output logic        done
`ifdef TRIAD_ENCODE_DROPCNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT1  = 3'd2,
        BIT2  = 3'd3,
        DEAD  = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  hit_idx;   // latched hit index k
    logic [3:0]  dead_lat;  // latched dead time for the triad in flight
    logic [3:0]  dead_ctr;  // remaining dead cycles while in DEAD

    logic hit_req;
    assign hit_req = inject && (h_strip != 4'd0);

    // Lowest set bit wins; higher hits in the same channel are ignored.
    function automatic logic [1:0] lowest_hit(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Sequencer: state and every output are registered together so the
    // outputs never depend combinationally on the inputs.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples pre-edge values; blocking would create order-dependent races.
        if (reset) begin
            state    <= IDLE;
            triad    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit_idx  <= 2'd0;
            dead_lat <= 4'd0;
            dead_ctr <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_req) begin
                        state    <= START;
                        hit_idx  <= lowest_hit(h_strip);
                        dead_lat <= dead;
                        triad    <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        triad <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    state <= BIT1;
                    triad <= hit_idx[1];
                end
                BIT1: begin
                    state <= BIT2;
                    triad <= hit_idx[0];
                    done  <= 1'b1;
                end
                BIT2: begin
                    triad <= 1'b0;
                    if (dead_lat != 4'd0) begin
                        state    <= DEAD;
                        dead_ctr <= dead_lat;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DEAD: begin
                    triad    <= 1'b0;
                    dead_ctr <= dead_ctr - 4'd1;
                    if (dead_ctr == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    triad <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIAD_ENCODE_DROPCNT_EN
    // Count valid requests that arrive while a triad is in flight; saturate.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= 16'd0;
        end else if (hit_req && (state != IDLE) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_triad_encode.sv
// tb_triad_encode: directed stimulus with a done-triggered scoreboard for
// triad_encode. Define TRIAD_ENCODE_DROPCNT_EN to also exercise drop_cnt.
`timescale 1ns/1ps
module tb_triad_encode;

    logic        clock = 1'b0;
    logic        reset;
    logic        inject;
    logic [3:0]  h_strip;
    logic [3:0]  dead;
    logic        triad;
    logic        busy;
    logic        done;
`ifdef TRIAD_ENCODE_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] bits;   // expected triad, first bit in MSB
        int         dead;   // expected dead-time length
    } exp_t;

    exp_t sb_q[$];

    triad_encode dut (
        .clock   (clock),
        .reset   (reset),
        .inject  (inject),
        .h_strip (h_strip),
        .dead    (dead),
        .triad   (triad),
        .busy    (busy),
        .done    (done)
`ifdef TRIAD_ENCODE_DROPCNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #12 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] bits, input int dl);
        exp_t e;
        e.bits = bits;
        e.dead = dl;
        sb_q.push_back(e);
    endtask

    // Monitor: on every done pulse, pop the expected triad and compare the
    // last three triad bits, then measure the following dead time.
    initial begin
        logic [2:0] hist;
        bit         pending;
        int         cnt;
        int         exp_dead;
        exp_t       e;
        hist    = 3'b000;
        pending = 1'b0;
        cnt     = 0;
        exp_dead = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hist    = 3'b000;
                pending = 1'b0;
            end else begin
                hist = {hist[1:0], triad};
                if (pending) begin
                    if (busy) begin
                        cnt++;
                        check("dead_triad_low", {31'd0, triad}, 32'd0);
                    end else begin
                        check("dead_len", cnt, exp_dead);
                        pending = 1'b0;
                    end
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", sb_q.size(), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("triad_bits", {29'd0, hist}, {29'd0, e.bits});
                        pending  = 1'b1;
                        exp_dead = e.dead;
                        cnt      = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] pat_triad;
        pat_triad = 4'b1010;   // 1,0,1 then the IDLE 0
        reset   = 1'b1;
        inject  = 1'b0;
        h_strip = 4'd0;
        dead    = 4'd0;
        step();
        step();
        check("rst_triad", {31'd0, triad}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
`ifdef TRIAD_ENCODE_DROPCNT_EN
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
`endif

        // Request on the first edge after reset release: k=2 -> 1,1,0.
        reset = 1'b0; inject = 1'b1; h_strip = 4'b0100; dead = 4'd0;
        push(3'b110, 0);
        step();
        inject = 1'b0;
        check("t1_n1_triad", {31'd0, triad}, 32'd1);
        check("t1_n1_busy",  {31'd0, busy},  32'd1);
        check("t1_n1_done",  {31'd0, done},  32'd0);
        step();
        check("t1_n2_triad", {31'd0, triad}, 32'd1);
        step();
        check("t1_n3_triad", {31'd0, triad}, 32'd0);
        check("t1_n3_done",  {31'd0, done},  32'd1);
        step();
        check("t1_n4_busy",  {31'd0, busy},  32'd0);
        check("t1_n4_done",  {31'd0, done},  32'd0);

        // k=0 with dead=3; inputs change in flight; second request dropped.
        inject = 1'b1; h_strip = 4'b1011; dead = 4'd3;
        push(3'b100, 3);
        step();
        inject = 1'b0; h_strip = 4'b0100; dead = 4'd0;
        check("t2_n1_triad", {31'd0, triad}, 32'd1);
        step();
        check("t2_n2_triad", {31'd0, triad}, 32'd0);
        step();
        check("t2_n3_done",  {31'd0, done},  32'd1);
        step();
        check("t2_n4_busy",  {31'd0, busy},  32'd1);
        step();
        inject = 1'b1; h_strip = 4'b1111;
        check("t2_n5_busy",  {31'd0, busy},  32'd1);
        step();
        inject = 1'b0;
        check("t2_n6_busy",  {31'd0, busy},  32'd1);
        check("t2_n6_triad", {31'd0, triad}, 32'd0);
        step();
        check("t2_n7_busy",  {31'd0, busy},  32'd0);
`ifdef TRIAD_ENCODE_DROPCNT_EN
        check("t2_drop", {16'd0, drop_cnt}, 32'd1);
`endif

        // Empty hit vector is ignored.
        inject = 1'b1; h_strip = 4'b0000;
        repeat (3) begin
            step();
            check("t3_triad", {31'd0, triad}, 32'd0);
            check("t3_busy",  {31'd0, busy},  32'd0);
        end
        inject = 1'b0;
`ifdef TRIAD_ENCODE_DROPCNT_EN
        check("t3_drop", {16'd0, drop_cnt}, 32'd1);
`endif

        // Reset during BIT1 aborts the triad; reset beats inject.
        inject = 1'b1; h_strip = 4'b0001; dead = 4'd0;
        step();
        inject = 1'b0;
        step();
        reset = 1'b1; inject = 1'b1; h_strip = 4'b1000;
        step();
        check("t4_rst_triad", {31'd0, triad}, 32'd0);
        check("t4_rst_busy",  {31'd0, busy},  32'd0);
        check("t4_rst_done",  {31'd0, done},  32'd0);
        step();
        check("t4_rst_prio",  {31'd0, busy},  32'd0);
`ifdef TRIAD_ENCODE_DROPCNT_EN
        check("t4_drop", {16'd0, drop_cnt}, 32'd0);
`endif
        reset = 1'b0;
        push(3'b111, 0);
        step();
        inject = 1'b0;
        check("t4_n1_triad", {31'd0, triad}, 32'd1);
        step();
        check("t4_n2_triad", {31'd0, triad}, 32'd1);
        step();
        check("t4_n3_triad", {31'd0, triad}, 32'd1);
        step();
        check("t4_n4_busy",  {31'd0, busy},  32'd0);

        // Continuous inject, k=1, dead=0: 4-cycle period.
        inject = 1'b1; h_strip = 4'b0010; dead = 4'd0;
        repeat (3) push(3'b101, 0);
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 11) inject = 1'b0;
            check("t5_triad", {31'd0, triad}, {31'd0, pat_triad[3 - ((i - 1) % 4)]});
            check("t5_done",  {31'd0, done},  (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        step();
        check("t5_busy_end", {31'd0, busy}, 32'd0);
`ifdef TRIAD_ENCODE_DROPCNT_EN
        check("t5_drop", {16'd0, drop_cnt}, 32'd8);

        // Saturation: 3641 frames of dead=15 with inject held give 65538 drops.
        inject = 1'b1; h_strip = 4'b0001; dead = 4'd15;
        for (int f = 0; f < 3641; f++) begin
            push(3'b100, 15);
            repeat (19) step();
        end
        inject = 1'b0;
        check("t6_drop_sat", {16'd0, drop_cnt}, 32'h0000FFFF);
`endif

        repeat (3) step();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
